// File: rtl/ysyx_22040750_axi_rd_responder_pkg.sv
// Shared constants for the AXI4 read responder: burst types, response codes, FSM states.
// Also holds the address-window decode helper used at AR acceptance.
package ysyx_22040750_axi_rd_responder_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSV   = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Subtract first so a window touching the top of the address space cannot overflow.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    return (addr >= base) && ((addr - base) < size);
  endfunction

endpackage

// File: rtl/ysyx_22040750_axi_rd_responder_if.sv
// AR / R / backing-memory signal bundle; slave = responder side, master = requester + memory.
interface ysyx_22040750_axi_rd_responder_if #(
  parameter int DATA_W = 64
);
  logic              I_arvalid;
  logic              O_arready;
  logic [31:0]       I_araddr;
  logic [7:0]        I_arlen;
  logic [2:0]        I_arsize;
  logic [1:0]        I_arburst;

  logic [DATA_W-1:0] O_rdata;
  logic [1:0]        O_rresp;
  logic              O_rlast;
  logic              O_rvalid;
  logic              I_rready;

  logic              O_mem_ren;
  logic [31:0]       O_mem_addr;
  logic [DATA_W-1:0] I_mem_rdata;

  modport slave (
    input  I_arvalid, I_araddr, I_arlen, I_arsize, I_arburst,
    output O_arready,
    output O_rdata, O_rresp, O_rlast, O_rvalid,
    input  I_rready,
    output O_mem_ren, O_mem_addr,
    input  I_mem_rdata
  );

  modport master (
    output I_arvalid, I_araddr, I_arlen, I_arsize, I_arburst,
    input  O_arready,
    input  O_rdata, O_rresp, O_rlast, O_rvalid,
    output I_rready,
    input  O_mem_ren, O_mem_addr,
    output I_mem_rdata
  );
endinterface

// File: rtl/ysyx_22040750_axi_burst_addrgen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts plus WRAP length legality.
// Zero latency; no handshake.
module ysyx_22040750_axi_burst_addrgen
  import ysyx_22040750_axi_rd_responder_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        wrap_ok
);

  logic [31:0] step;
  logic [31:0] span;
  logic [31:0] wrap_mask;
  logic [31:0] incr_addr;

  always_comb begin
    step      = 32'd1 << size;
    span      = ({24'd0, len} + 32'd1) << size;
    wrap_mask = span - 32'd1;
    incr_addr = addr + step;
    wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

    unique case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/ysyx_22040750_axi_rd_responder.sv
// AXI4 read responder: one AR at a time, beats from a 1-cycle sync memory into a 2-entry R FIFO.
// AR->mem_ren 1 cycle, AR->rvalid 2 cycles; issue throttles on FIFO occupancy so rready stalls never drop beats.
module ysyx_22040750_axi_rd_responder
  import ysyx_22040750_axi_rd_responder_pkg::*;
#(
  parameter int          DATA_W    = 64,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0800_0000,
  parameter int          AR_DELAY  = 0
)(
  input  logic I_clk,
  input  logic I_rst,
  ysyx_22040750_axi_rd_responder_if.slave bus
);

  localparam logic [15:0] WAIT_LAST = 16'(AR_DELAY - 1);

  state_e      state_q, state_d;
  logic [31:0] beat_addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        dec_err_q;
  logic [7:0]  beat_cnt_q;
  logic [15:0] wait_cnt_q;

  // R FIFO. A pending entry was pushed alongside a memory read; its data is the live
  // memory output for one cycle, then gets captured so it stays stable under stall.
  logic [1:0]        cnt_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [DATA_W-1:0] ent_data_q [2];
  logic [1:0]        ent_resp_q [2];
  logic              ent_last_q [2];
  logic              ent_pend_q [2];

  logic [31:0] next_addr;
  logic        wrap_ok;
  logic        ar_fire;
  logic        issue;
  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        mem_ren;
  logic        last_issue;
  logic [1:0]  beat_resp;

  ysyx_22040750_axi_burst_addrgen u_addrgen (
    .addr      (beat_addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .wrap_ok   (wrap_ok)
  );

  assign bus.O_arready = (state_q == ST_IDLE) && !I_rst;
  assign ar_fire       = bus.I_arvalid && bus.O_arready;
  assign fifo_empty    = (cnt_q == 2'd0);
  assign pop           = !fifo_empty && bus.I_rready;
  assign push          = issue;
  assign last_issue    = (beat_cnt_q == len_q);

  always_comb begin
    if (dec_err_q) begin
      beat_resp = RESP_DECERR;
    end else if ((burst_q == BURST_RSV) || ((burst_q == BURST_WRAP) && !wrap_ok)) begin
      beat_resp = RESP_SLVERR;
    end else begin
      beat_resp = RESP_OKAY;
    end
  end

  assign mem_ren        = issue && (beat_resp == RESP_OKAY);
  assign bus.O_mem_ren  = mem_ren;
  assign bus.O_mem_addr = mem_ren ? (beat_addr_q & ~32'd7) : 32'd0;

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ar_fire) begin
          state_d = (AR_DELAY > 0) ? ST_WAIT : ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Never push into a full FIFO, even if it pops this cycle.
        if (cnt_q < 2'd2) begin
          issue = 1'b1;
          if (last_issue) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if ((cnt_q == 2'd1) && pop) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      beat_addr_q <= 32'd0;
      len_q       <= 8'd0;
      size_q      <= 3'd0;
      burst_q     <= BURST_FIXED;
      dec_err_q   <= 1'b0;
      beat_cnt_q  <= 8'd0;
      wait_cnt_q  <= 16'd0;
    end else if (ar_fire) begin
      beat_addr_q <= bus.I_araddr;
      len_q       <= bus.I_arlen;
      size_q      <= bus.I_arsize;
      burst_q     <= bus.I_arburst;
      dec_err_q   <= !addr_in_window(bus.I_araddr, ADDR_BASE, ADDR_SIZE);
      beat_cnt_q  <= 8'd0;
      wait_cnt_q  <= 16'd0;
    end else begin
      if (state_q == ST_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end
      if (issue) begin
        beat_addr_q <= next_addr;
        beat_cnt_q  <= beat_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      cnt_q    <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        ent_data_q[i] <= '0;
        ent_resp_q[i] <= RESP_OKAY;
        ent_last_q[i] <= 1'b0;
        ent_pend_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (ent_pend_q[i]) begin
          ent_data_q[i] <= bus.I_mem_rdata;
          ent_pend_q[i] <= 1'b0;
        end
      end
      if (push) begin
        ent_data_q[wr_ptr_q] <= '0;
        ent_resp_q[wr_ptr_q] <= beat_resp;
        ent_last_q[wr_ptr_q] <= last_issue;
        ent_pend_q[wr_ptr_q] <= mem_ren;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign bus.O_rvalid = !fifo_empty;
  assign bus.O_rdata  = fifo_empty           ? '0 :
                        ent_pend_q[rd_ptr_q] ? bus.I_mem_rdata : ent_data_q[rd_ptr_q];
  assign bus.O_rresp  = fifo_empty ? RESP_OKAY : ent_resp_q[rd_ptr_q];
  assign bus.O_rlast  = !fifo_empty && ent_last_q[rd_ptr_q];

endmodule
